// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI input front end.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [7:0] SYS_BASE = 8'hF0;
   localparam logic [7:0] RT_BASE  = 8'hF8;

   localparam logic [1:0] U_IDLE  = 2'd0;
   localparam logic [1:0] U_START = 2'd1;
   localparam logic [1:0] U_DATA  = 2'd2;
   localparam logic [1:0] U_STOP  = 2'd3;

   localparam logic [1:0] P_IDLE = 2'd0;
   localparam logic [1:0] P_NOTE = 2'd1;
   localparam logic [1:0] P_VEL  = 2'd2;

   // True when a status byte is Note On/Off on an accepted channel.
   function automatic logic note_match(input logic [7:0] st, input logic omni,
                                       input logic [3:0] ch);
      return ((st[7:4] == NOTE_OFF) || (st[7:4] == NOTE_ON)) && (omni || (st[3:0] == ch));
   endfunction

endpackage

// File: rtl/midi_in_parser_if.sv
// Note-event output bundle from the MIDI parser towards midi_player.
interface midi_in_parser_if;
   logic [7:0] midi_data;
   logic       midi_valid;
   logic       note_on;
   logic [6:0] velocity;
   logic       frame_err;

   modport master (output midi_data, midi_valid, note_on, velocity, frame_err);
   modport slave  (input  midi_data, midi_valid, note_on, velocity, frame_err);
endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling timer and byte FSM.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 3200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_ready_c,
   output logic       frame_err_c
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   logic             meta_q, sync_q, prev_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             cnt_zero;

   // Synchronizer plus one delay stage for falling-edge detection; idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= U_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      byte_ready_c = 1'b0;
      frame_err_c  = 1'b0;
      case (state_q)
         U_IDLE: begin
            if (prev_q && !sync_q) begin
               state_d = U_START;
               cnt_d   = CNT_W'(HALF - 1);
            end
         end
         U_START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!sync_q) begin
               state_d = U_DATA;
               cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
               bit_d   = 3'd0;
            end else begin
               state_d = U_IDLE;
            end
         end
         U_DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shreg_d = {sync_q, shreg_q[7:1]};
               cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = U_STOP;
            end
         end
         U_STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Leave at mid-stop so a start edge in its second half is caught.
               state_d      = U_IDLE;
               byte_ready_c = sync_q;
               frame_err_c  = !sync_q;
            end
         end
         default: state_d = U_IDLE;
      endcase
   end

   assign byte_o = shreg_q;

endmodule

// File: rtl/midi_in_parser.sv
// MIDI input front end: UART receive plus Note On/Off parser with running status.
module midi_in_parser
   import midi_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned BAUD    = 31250,
   parameter int unsigned CHANNEL = 0,
   parameter int unsigned OMNI    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              midi_rx,
   midi_in_parser_if.master  ev
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [3:0]  CH           = 4'(CHANNEL);
   localparam logic        OMNI_EN      = (OMNI != 0);

   logic [7:0] rx_byte;
   logic       byte_ready_c, frame_err_c;

   logic [1:0] pstate_q, pstate_d;
   logic [7:0] rs_q, rs_d;
   logic [6:0] note_q, note_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       note_on_q, note_on_d;
   logic [6:0] vel_q, vel_d;
   logic       ferr_q, ferr_d;

   midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (midi_rx),
      .byte_o       (rx_byte),
      .byte_ready_c (byte_ready_c),
      .frame_err_c  (frame_err_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pstate_q  <= P_IDLE;
         rs_q      <= '0;
         note_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         note_on_q <= 1'b0;
         vel_q     <= '0;
         ferr_q    <= 1'b0;
      end else begin
         pstate_q  <= pstate_d;
         rs_q      <= rs_d;
         note_q    <= note_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         note_on_q <= note_on_d;
         vel_q     <= vel_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      pstate_d  = pstate_q;
      rs_d      = rs_q;
      note_d    = note_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      note_on_d = note_on_q;
      vel_d     = vel_q;
      ferr_d    = frame_err_c;
      if (frame_err_c) begin
         pstate_d = P_IDLE;
         rs_d     = '0;
      end else if (byte_ready_c) begin
         if (rx_byte >= RT_BASE) begin
            // Real-time bytes are transparent to the message in progress.
         end else if (rx_byte >= SYS_BASE) begin
            pstate_d = P_IDLE;
            rs_d     = '0;
         end else if (rx_byte[7]) begin
            rs_d     = rx_byte;
            pstate_d = note_match(rx_byte, OMNI_EN, CH) ? P_NOTE : P_IDLE;
         end else begin
            case (pstate_q)
               P_IDLE: begin
                  if (note_match(rs_q, OMNI_EN, CH)) begin
                     note_d   = rx_byte[6:0];
                     pstate_d = P_VEL;
                  end
               end
               P_NOTE: begin
                  note_d   = rx_byte[6:0];
                  pstate_d = P_VEL;
               end
               P_VEL: begin
                  vel_d     = rx_byte[6:0];
                  data_d    = {1'b0, note_q};
                  valid_d   = 1'b1;
                  note_on_d = (rs_q[7:4] == NOTE_ON) && (rx_byte[6:0] != 7'd0);
                  pstate_d  = P_NOTE;
               end
               default: pstate_d = P_IDLE;
            endcase
         end
      end
   end

   assign ev.midi_data  = data_q;
   assign ev.midi_valid = valid_q;
   assign ev.note_on    = note_on_q;
   assign ev.velocity   = vel_q;
   assign ev.frame_err  = ferr_q;

endmodule
